// File: rtl/mem_write_buffer.sv
// Write buffer between the DMA slave memory port and a single-port SRAM:
// a DEPTH-entry FIFO of word writes drained by a two-state request/ack FSM.
module mem_write_buffer #(
    parameter int DEPTH   = 4,
    parameter int SRAM_AW = 10
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [31:0]               mem_WR_addr,
    input  logic                      mem_write_flag,
    input  logic [31:0]               HWDATA_toMem,
    output logic                      sram_req,
    output logic [SRAM_AW-1:0]        sram_addr,
    output logic [31:0]               sram_wdata,
    input  logic                      sram_ack,
    output logic                      buf_full,
    output logic                      buf_empty,
    output logic [$clog2(DEPTH):0]    buf_count,
    output logic [15:0]               words_written,
    output logic                      overflow_err,
    output logic                      misalign_err,
    output logic                      dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = SRAM_AW + 32;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q, count_d;
    logic [SRAM_AW-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [15:0]       words_q;
    logic              ovf_q, mis_q;
    logic              aligned, push, pop, ack_done;
    logic [EW-1:0]     head;
    logic              unused_addr_bits;

    // Upper address bits fall outside the SRAM and are discarded.
    assign unused_addr_bits = ^mem_WR_addr[31:SRAM_AW+2];

    assign aligned  = (mem_WR_addr[1:0] == 2'b00);
    assign buf_full  = (count_q == CNT_FULL);
    assign buf_empty = (count_q == '0);
    // Full is judged on the pre-edge occupancy, so a same-edge pop never rescues a push.
    assign push = mem_write_flag && aligned && !buf_full;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        ack_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!buf_empty) begin
                    pop     = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (sram_ack) begin
                    ack_done = 1'b1;
                    if (!buf_empty) pop = 1'b1;
                    else            state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            words_q  <= '0;
            ovf_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                addr_q   <= head[EW-1:32];
                wdata_q  <= head[31:0];
            end
            if (ack_done && (words_q != 16'hFFFF)) words_q <= words_q + 16'd1;
            if (mem_write_flag && !aligned)            mis_q <= 1'b1;
            if (mem_write_flag && aligned && buf_full) ovf_q <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge HCLK) begin
        if (push) mem_q[wr_ptr_q] <= {mem_WR_addr[SRAM_AW+1:2], HWDATA_toMem};
    end

    assign sram_req      = (state_q == S_REQ);
    assign sram_addr     = addr_q;
    assign sram_wdata    = wdata_q;
    assign buf_count     = count_q;
    assign words_written = words_q;
    assign overflow_err  = ovf_q;
    assign misalign_err  = mis_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the buffer and the SRAM port.
module tb_mem_write_buffer;

    localparam int DEPTH   = 4;
    localparam int SRAM_AW = 10;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] mem_WR_addr = '0;
    logic        mem_write_flag = 1'b0;
    logic [31:0] HWDATA_toMem = '0;
    logic        sram_ack = 1'b0;
    logic        sram_req;
    logic [SRAM_AW-1:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        buf_full, buf_empty;
    logic [$clog2(DEPTH):0] buf_count;
    logic [15:0] words_written;
    logic        overflow_err, misalign_err, dbg_state;

    mem_write_buffer #(.DEPTH(DEPTH), .SRAM_AW(SRAM_AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .mem_WR_addr(mem_WR_addr),
        .mem_write_flag(mem_write_flag), .HWDATA_toMem(HWDATA_toMem),
        .sram_req(sram_req), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_ack(sram_ack), .buf_full(buf_full), .buf_empty(buf_empty),
        .buf_count(buf_count), .words_written(words_written),
        .overflow_err(overflow_err), .misalign_err(misalign_err), .dbg_state(dbg_state)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [SRAM_AW-1:0] a;
        logic [31:0]        d;
    } ent_t;

    ent_t m_fifo[$];
    bit   m_busy;
    ent_t m_cur;
    int   m_words;
    bit   m_ovf, m_mis;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_fifo.delete();
        m_busy  = 0;
        m_cur   = '0;
        m_words = 0;
        m_ovf   = 0;
        m_mis   = 0;
    endtask

    // One clock edge of the intended behaviour, from the pre-edge inputs.
    task automatic model_edge();
        int old_size;
        old_size = m_fifo.size();
        if (m_busy && sram_ack) begin
            if (m_words < 65535) m_words++;
            m_busy = 0;
        end
        if (!m_busy && old_size > 0) begin
            m_cur  = m_fifo.pop_front();
            m_busy = 1;
        end
        if (mem_write_flag) begin
            if (mem_WR_addr[1:0] != 2'b00) m_mis = 1;
            else if (old_size == DEPTH)    m_ovf = 1;
            else m_fifo.push_back({mem_WR_addr[SRAM_AW+1:2], HWDATA_toMem});
        end
    endtask

    task automatic check_all();
        chk("sram_req", 32'(sram_req), 32'(m_busy));
        if (m_busy) begin
            chk("sram_addr", 32'(sram_addr), 32'(m_cur.a));
            chk("sram_wdata", sram_wdata, m_cur.d);
        end
        chk("buf_count", 32'(buf_count), 32'(m_fifo.size()));
        chk("buf_full", 32'(buf_full), 32'(m_fifo.size() == DEPTH));
        chk("buf_empty", 32'(buf_empty), 32'(m_fifo.size() == 0));
        chk("words_written", 32'(words_written), 32'(m_words));
        chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
        chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    endtask

    // Drive inputs (called just after a falling edge), take one rising edge, check at the falling edge.
    task automatic cyc(input bit f, input logic [31:0] a, input logic [31:0] d, input bit k);
        mem_write_flag = f;
        mem_WR_addr    = a;
        HWDATA_toMem   = d;
        sram_ack       = k;
        @(posedge HCLK);
        if (HRESETn) model_edge();
        @(negedge HCLK);
        check_all();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"}, 32'(sram_req), 32'd0);
        chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
        chk({tag, "_wdata"}, sram_wdata, 32'd0);
        chk({tag, "_count"}, 32'(buf_count), 32'd0);
        chk({tag, "_empty"}, 32'(buf_empty), 32'd1);
        chk({tag, "_full"}, 32'(buf_full), 32'd0);
        chk({tag, "_words"}, 32'(words_written), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow_err), 32'd0);
        chk({tag, "_mis"}, 32'(misalign_err), 32'd0);
    endtask

    // Asserts reset mid-cycle, checks outputs before any edge, releases after a falling edge.
    task automatic do_reset(input string tag);
        #2;
        HRESETn = 1'b0;
        #1;
        check_reset_values(tag);
        model_clear();
        mem_write_flag = 1'b0;
        sram_ack       = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        int run, max_run, max_cnt;
        logic [31:0] a, d;
        model_clear();

        // Power-on reset
        @(negedge HCLK);
        @(negedge HCLK);
        check_reset_values("por");
        HRESETn = 1'b1;

        // Single write with ack tied high; push on the first edge after release
        cyc(1, 32'h0000_0010, 32'hDEAD_BEEF, 1);
        cyc(0, 32'h0, 32'h0, 1);
        chk("single_req", 32'(sram_req), 32'd1);
        chk("single_addr", 32'(sram_addr), 32'd4);
        chk("single_data", sram_wdata, 32'hDEAD_BEEF);
        cyc(0, 32'h0, 32'h0, 1);
        chk("single_words", 32'(words_written), 32'd1);
        chk("single_empty", 32'(buf_empty), 32'd1);

        // Streaming: eight back-to-back writes with ack high
        do_reset("rst_stream");
        run = 0; max_run = 0; max_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) cyc(1, 32'(i * 4), $urandom, 1);
            else       cyc(0, 32'h0, 32'h0, 1);
            run = sram_req ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (int'(buf_count) > max_cnt) max_cnt = int'(buf_count);
        end
        chk("stream_run", 32'(max_run), 32'd8);
        chk("stream_maxcnt", 32'(max_cnt), 32'd1);
        chk("stream_words", 32'(words_written), 32'd8);

        // Back-pressure and overflow
        do_reset("rst_ovf");
        for (int i = 0; i < 6; i++) cyc(1, 32'(i * 4), 32'hA000_0000 + 32'(i), 0);
        chk("ovf_full", 32'(buf_full), 32'd1);
        chk("ovf_err", 32'(overflow_err), 32'd1);
        chk("ovf_head", 32'(sram_addr), 32'd0);
        for (int i = 0; i < 7; i++) cyc(0, 32'h0, 32'h0, 1);
        chk("ovf_words", 32'(words_written), 32'd5);
        chk("ovf_idle", 32'(sram_req), 32'd0);

        // Stall then ack
        do_reset("rst_stall");
        cyc(1, 32'h0000_0040, 32'h1234_5678, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 32'h0, 32'h0, 0);
            chk("stall_addr", 32'(sram_addr), 32'h10);
            chk("stall_data", sram_wdata, 32'h1234_5678);
        end
        cyc(0, 32'h0, 32'h0, 1);
        chk("stall_release", 32'(sram_req), 32'd0);

        // Misaligned write dropped
        cyc(1, 32'h0000_0006, 32'hBAD0_BAD0, 0);
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_count", 32'(buf_count), 32'd0);
        cyc(0, 32'h0, 32'h0, 0);
        chk("mis_noreq", 32'(sram_req), 32'd0);

        // Reset mid-operation with entries queued and one in flight
        do_reset("rst_pre");
        for (int i = 0; i < 4; i++) cyc(1, 32'h100 + 32'(i * 4), $urandom, 0);
        chk("mid_count", 32'(buf_count), 32'd3);
        do_reset("rst_mid");
        for (int i = 0; i < 5; i++) begin
            cyc(0, 32'h0, 32'h0, 1);
            chk("mid_noreq", 32'(sram_req), 32'd0);
        end

        // Random traffic, including misaligned and out-of-range addresses
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            if ($urandom_range(0, 15) != 0) a[1:0] = 2'b00;
            d = $urandom;
            cyc(bit'($urandom_range(0, 1)), a, d, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 8; i++) cyc(0, 32'h0, 32'h0, 1);
        chk("final_empty", 32'(buf_empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_write_buffer.md
MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter SRAM_AW, default 10, SRAM word-address width.
REQ-003 HCLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 HRESETn  input  1  asynchronous, active-low reset.
REQ-005 mem_WR_addr  input  32  byte address of the write from the DMA slave memory port.
REQ-006 mem_write_flag  input  1  one-cycle write strobe; each HCLK edge where it is high is one write request.
REQ-007 HWDATA_toMem  input  32  write data, valid with mem_write_flag.
REQ-008 sram_req  output  1  SRAM write request.
REQ-009 sram_addr  output  SRAM_AW  SRAM word address.
REQ-010 sram_wdata  output  32  SRAM write data.
REQ-011 sram_ack  input  1  SRAM accepted the current request.
REQ-012 buf_full  output  1  FIFO holds DEPTH entries.
REQ-013 buf_empty  output  1  FIFO holds 0 entries.
REQ-014 buf_count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 words_written  output  16  count of SRAM writes completed.
REQ-016 overflow_err  output  1  sticky; a write was dropped because the FIFO was full.
REQ-017 misalign_err  output  1  sticky; a write was dropped because mem_WR_addr[1:0] was not 2'b00.

Function
REQ-018 Push: on an edge with mem_write_flag=1, aligned address and buf_count<DEPTH, the block SHALL enqueue {mem_WR_addr[SRAM_AW+1:2], HWDATA_toMem}.
REQ-019 A push while buf_full=1 SHALL be dropped and SHALL set overflow_err, even if a pop occurs on the same edge.
REQ-020 A push with mem_WR_addr[1:0]!=0 SHALL be dropped and SHALL set misalign_err. The alignment check takes precedence over the full check. The FIFO SHALL be unchanged.
REQ-021 Address bits above SRAM_AW+1 SHALL be ignored, with no wrap detection.
REQ-022 Drain FSM states: IDLE and REQ.
REQ-023 IDLE: when buf_empty=0, the FSM SHALL pop the head into sram_addr/sram_wdata, drive sram_req=1 and go to REQ; otherwise it stays in IDLE with sram_req=0.
REQ-024 REQ: sram_req, sram_addr and sram_wdata SHALL stay stable until an edge with sram_ack=1.
REQ-025 REQ with sram_ack=1: words_written SHALL increment. If the FIFO is non-empty, the FSM SHALL pop the next entry on the same edge and stay in REQ (back-to-back, one write per cycle). Otherwise it SHALL drop sram_req and go to IDLE.
REQ-026 sram_ack sampled in IDLE SHALL be ignored.
REQ-027 Latency: a write pushed into an empty FIFO while in IDLE SHALL appear as sram_req=1 one cycle after the push edge.
REQ-028 Simultaneous push and pop SHALL leave buf_count unchanged and preserve FIFO order.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 buf_full, buf_empty and buf_count SHALL be registered-consistent with FIFO contents after each edge.
REQ-031 words_written SHALL saturate at 16'hFFFF.
REQ-032 overflow_err and misalign_err SHALL clear only on reset.

Reset
REQ-033 HRESETn=0 SHALL immediately force: FSM=IDLE, sram_req=0, sram_addr=0, sram_wdata=0, pointers=0, buf_count=0, buf_empty=1, buf_full=0, words_written=0, overflow_err=0, misalign_err=0.
REQ-034 Reset mid-transfer SHALL discard all queued and in-flight writes; no sram_req SHALL be asserted until a new push after reset release.
REQ-035 The first push SHALL be accepted on the first rising edge after HRESETn deasserts.

Verification
REQ-036 Single write: addr 0x0000_0010, data 0xDEADBEEF, sram_ack tied 1 -> next cycle sram_req=1, sram_addr=4, sram_wdata=0xDEADBEEF; words_written=1; buf_empty=1 after.
REQ-037 Back-pressure and overflow: sram_ack=0, 6 consecutive writes to 0x0,0x4,...,0x14 -> first write held on the SRAM port, next 4 queued (buf_full=1), 6th dropped with overflow_err=1. Release ack -> addresses 0..4 written in order, words_written=5.
REQ-038 Streaming: 8 consecutive writes with sram_ack=1 -> sram_req high 8 consecutive cycles with no bubbles, buf_count<=1, words_written=8.
REQ-039 Misalign: write to 0x0000_0006 -> misalign_err=1, no sram_req, buf_count=0.
REQ-040 Reset mid-operation: 3 entries queued with ack=0, assert HRESETn=0 asynchronously -> all outputs reach reset values before the next edge; no SRAM write follows release.
REQ-041 Stall then ack: hold sram_ack=0 for 5 cycles with 1 entry -> sram_addr and sram_wdata stable for all 5 cycles; on ack, sram_req=0 next cycle.
